// File: rtl/uart_tx_feeder.sv
// Byte FIFO that sequences buffered bytes into uart_tx one frame at a time; first send_en two edges after a write into an idle, empty block.
// Writes are dropped (overflow pulse) when full; the next frame waits for tx_done plus GAP_CYCLES idle clocks.
module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic          clock,
    input  logic          n_reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_send_en,
    input  logic          tx_done,
    output logic          busy
);

    localparam int          GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [GW-1:0] gap_cnt;
    logic          is_full;
    logic          accept;
    logic          pop;
    logic [AW:0]   count_next;

    // Full is judged on the pre-edge count, so a pop on the same edge does not rescue a write.
    assign is_full = (count == DEPTH_C);
    assign accept  = wr_en && !is_full;
    assign pop     = (state == ST_IDLE) && (count != '0);

    always_comb begin
        count_next = count;
        if (accept && !pop) begin
            count_next = count + ONE;
        end else if (!accept && pop) begin
            count_next = count - ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (n_reset && accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count    <= count_next;
            full     <= (count_next == DEPTH_C);
            empty    <= (count_next == '0);
            overflow <= wr_en && is_full;
        end
    end

    // Send sequencer; tx_send_en and busy are registered alongside the state they decode.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state      <= ST_IDLE;
            rd_ptr     <= '0;
            tx_data    <= 8'h00;
            tx_send_en <= 1'b0;
            busy       <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data    <= mem[rd_ptr];
                        rd_ptr     <= rd_ptr + 1'b1;
                        state      <= ST_SEND;
                        tx_send_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_SEND: begin
                    state      <= ST_WAIT;
                    tx_send_en <= 1'b0;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (GAP_CYCLES > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    tx_send_en <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
